// File: rtl/tq_row_gather_32.sv
// Gathers 1, 2 or 4 eight-sample input beats into one 32-sample residual row for
// the 32-point butterfly, tracking the row index within the current transform block.
module tq_row_gather_32 #(
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_size,
  input  logic [8*DATA_W-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*DATA_W-1:0]   out_data,
  output logic [1:0]             out_size,
  output logic                   out_bfly_en,
  output logic [4:0]             out_row,
  output logic                   out_last
);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t                state;
  logic [1:0]            cnt;
  logic                  acc;
  logic                  hs;
  logic                  first;
  logic                  done;
  logic [1:0]            bidx;
  logic [1:0]            size_n;
  logic [4:0]            row_n;
  logic [32*DATA_W-1:0]  data_n;

  function automatic logic [1:0] last_beat(input logic [1:0] sz);
    case (sz)
      2'd3:    last_beat = 2'd3;
      2'd2:    last_beat = 2'd1;
      default: last_beat = 2'd0;
    endcase
  endfunction

  function automatic logic [4:0] last_row(input logic [1:0] sz);
    case (sz)
      2'd0:    last_row = 5'd3;
      2'd1:    last_row = 5'd7;
      2'd2:    last_row = 5'd15;
      default: last_row = 5'd31;
    endcase
  endfunction

  assign out_valid = (state == FULL);
  assign in_ready  = (state != FULL) || out_ready;
  assign hs        = out_valid && out_ready;
  assign acc       = in_valid && in_ready;
  // Any accepted beat outside FILL opens a new row, including one overlapping a retire.
  assign first     = acc && (state != FILL);
  assign size_n    = first ? in_size : out_size;
  assign bidx      = first ? 2'd0 : cnt;
  assign done      = (bidx == last_beat(size_n));

  always_comb begin
    data_n = first ? '0 : out_data;
    for (int k = 0; k < 8; k++) begin
      if (size_n != 2'd0 || k < 4)
        data_n[(int'(bidx) * 8 + k) * DATA_W +: DATA_W] = in_data[k * DATA_W +: DATA_W];
    end
  end

  always_comb begin
    row_n = out_row;
    if (hs)
      row_n = (out_row == last_row(out_size)) ? 5'd0 : out_row + 5'd1;
    if (first && (in_size != out_size))
      row_n = 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      out_data    <= '0;
      out_size    <= 2'd0;
      out_row     <= 5'd0;
      out_last    <= 1'b0;
      out_bfly_en <= 1'b0;
    end else begin
      if (acc) begin
        out_data <= data_n;
        out_size <= size_n;
        cnt      <= done ? 2'd0 : 2'(bidx + 2'd1);
        state    <= done ? FULL : FILL;
      end else if (hs) begin
        state <= IDLE;
      end
      out_row     <= row_n;
      out_last    <= (row_n == last_row(size_n));
      out_bfly_en <= (size_n == 2'd3);
    end
  end

endmodule

// File: tb/tb_tq_row_gather_32.sv
// Bench for tq_row_gather_32: directed rows with literal expectations plus a
// randomized stream checked every cycle against a row-level reference model.
module tb_tq_row_gather_32;
  localparam int W = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_size = 2'd0;
  logic [8*W-1:0]  in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [32*W-1:0] out_data;
  logic [1:0]      out_size;
  logic            out_bfly_en;
  logic [4:0]      out_row;
  logic            out_last;

  tq_row_gather_32 #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_size(in_size), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_size(out_size), .out_bfly_en(out_bfly_en),
    .out_row(out_row), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [32*W-1:0] act, input logic [32*W-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: row contents as a sample array, row index by modulo arithmetic.
  logic [W-1:0]    mbuf [32];
  int              mnb = 0;
  int              msz = 0;
  int              mrow = 0;
  int              esz = 0;
  bit              mhave = 1'b0;
  logic [32*W-1:0] edata = '0;

  function automatic int nbeats(input int s);
    return (s == 3) ? 4 : (s == 2) ? 2 : 1;
  endfunction

  function automatic int nrows(input int s);
    return 4 << s;
  endfunction

  task automatic model_reset();
    mnb = 0; msz = 0; mrow = 0; mhave = 1'b0;
  endtask

  task automatic model_step();
    bit hs;
    bit acc;
    hs  = mhave && (out_ready === 1'b1);
    acc = (in_valid === 1'b1) && (!mhave || (out_ready === 1'b1));
    if (hs) begin
      mrow  = (mrow + 1) % nrows(esz);
      mhave = 1'b0;
    end
    if (acc) begin
      if (mnb == 0) begin
        if (int'(in_size) != msz) mrow = 0;
        msz = int'(in_size);
        for (int i = 0; i < 32; i++) mbuf[i] = '0;
      end
      for (int k = 0; k < 8; k++)
        if (msz != 0 || k < 4) mbuf[mnb * 8 + k] = in_data[k * W +: W];
      mnb++;
      if (mnb == nbeats(msz)) begin
        mnb   = 0;
        mhave = 1'b1;
        esz   = msz;
        for (int n = 0; n < 32; n++) edata[n * W +: W] = mbuf[n];
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_size", out_size, 0);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_bfly_en", out_bfly_en, 0);
      chk("rst_in_ready", in_ready, 1);
      model_reset();
    end else begin
      chk("out_valid", out_valid, mhave);
      chk("in_ready", in_ready, (!mhave || out_ready));
      if (mhave) begin
        chk("out_data", out_data, edata);
        chk("out_size", out_size, esz);
        chk("out_bfly_en", out_bfly_en, (esz == 3));
        chk("out_row", out_row, mrow);
        chk("out_last", out_last, (mrow == nrows(esz) - 1));
      end
      model_step();
    end
  end

  function automatic logic [32*W-1:0] ramp(input int base, input int nsamp);
    logic [32*W-1:0] v;
    v = '0;
    for (int n = 0; n < nsamp; n++) v[n * W +: W] = W'(base + n);
    return v;
  endfunction

  task automatic beat(input int sz, input logic [8*W-1:0] d);
    in_valid = 1'b1;
    in_size  = 2'(sz);
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  logic [32*W-1:0] full;

  initial begin
    do_reset();

    // Size 32 ramp row.
    out_ready = 1'b1;
    full = ramp(1, 32);
    for (int j = 0; j < 4; j++) beat(3, full[j * 8 * W +: 8 * W]);
    chk("s32_valid", out_valid, 1);
    chk("s32_data", out_data, ramp(1, 32));
    chk("s32_bfly", out_bfly_en, 1);
    chk("s32_row", out_row, 0);

    // Size 4 rows: only lanes 0..3 land, block of four wraps.
    do_reset();
    out_ready = 1'b1;
    full = ramp(5, 8);
    for (int r = 0; r < 5; r++) begin
      beat(0, full[8 * W - 1:0]);
      chk("s4_data", out_data, ramp(5, 4));
      chk("s4_bfly", out_bfly_en, 0);
      chk("s4_row", out_row, r % 4);
      chk("s4_last", out_last, (r == 3));
    end

    // Size 16 held under backpressure, then retire with a concurrent size 8 beat.
    do_reset();
    out_ready = 1'b0;
    full = ramp(200, 16);
    beat(2, full[8 * W - 1:0]);
    beat(2, full[16 * W - 1:8 * W]);
    chk("s16_data", out_data, ramp(200, 16));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_data", out_data, ramp(200, 16));
    end
    full = ramp(300, 8);
    in_valid = 1'b1; in_size = 2'd1; in_data = full[8 * W - 1:0]; out_ready = 1'b1;
    #1;
    chk("overlap_in_ready", in_ready, 1);
    chk("overlap_out_valid", out_valid, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("overlap_valid", out_valid, 1);
    chk("overlap_data", out_data, ramp(300, 8));
    chk("overlap_size", out_size, 1);
    chk("overlap_row", out_row, 0);

    // Reset in the middle of a size 32 row.
    do_reset();
    out_ready = 1'b1;
    full = ramp(50, 32);
    beat(3, full[8 * W - 1:0]);
    beat(3, full[16 * W - 1:8 * W]);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    rst_n = 1'b1;
    full = ramp(101, 32);
    for (int j = 0; j < 4; j++) beat(3, full[j * 8 * W +: 8 * W]);
    chk("postrst_data", out_data, ramp(101, 32));
    chk("postrst_row", out_row, 0);

    // Size changes on later beats are ignored.
    do_reset();
    out_ready = 1'b1;
    full = ramp(400, 32);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) beat((j == 0) ? 3 : 0, full[j * 8 * W +: 8 * W]);
      chk("latch_size", out_size, 3);
      chk("latch_data", out_data, ramp(400, 32));
      chk("latch_row", out_row, r);
    end

    // Back-to-back size 8 stream.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_size  = 2'd1;
      for (int k = 0; k < 8; k++) in_data[k * W +: W] = W'($urandom);
      @(posedge clk); #1;
      chk("s8_valid", out_valid, 1);
      chk("s8_row", out_row, i % 8);
      chk("s8_last", out_last, (i % 8 == 7));
    end
    in_valid = 1'b0;

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n     = ($urandom % 500 != 0);
      in_valid  = ($urandom % 4 != 0);
      if ($urandom % 6 == 0) in_size = 2'($urandom);
      for (int k = 0; k < 8; k++) in_data[k * W +: W] = W'($urandom);
      out_ready = ($urandom % 3 != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/tq_row_gather_32.md
TQ_ROW_GATHER_32 -- requirements
Module: tq_row_gather_32

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed residual sample width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  input beat valid.
REQ-005 SHALL have port in_ready  output  1  input beat accepted when in_valid&in_ready.
REQ-006 SHALL have port in_size  input  2  transform size, sampled on first beat of row: 0=4, 1=8, 2=16, 3=32.
REQ-007 SHALL have port in_data  input  8*DATA_W  eight signed samples; lane k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port out_valid  output  1  assembled row valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts row when out_valid&out_ready.
REQ-010 SHALL have port out_data  output  32*DATA_W  row samples 0..31, sample n at [n*DATA_W +: DATA_W], feeding the 32-point butterfly inputs i_0..i_31.
REQ-011 SHALL have port out_size  output  2  size of the presented row.
REQ-012 SHALL have port out_bfly_en  output  1  butterfly enable; 1 iff out_size==3.
REQ-013 SHALL have port out_row  output  5  row index of the presented row within its block.
REQ-014 SHALL have port out_last  output  1  presented row is the last row of its block (out_row==N-1).

Function
REQ-015 SHALL assemble one row from B beats: B=4 for size 32, B=2 for size 16, B=1 for sizes 4 and 8.
REQ-016 SHALL write beat j into samples 8j..8j+7; size 4 SHALL use lanes 0..3 only; all samples not written for the current row SHALL be zero.
REQ-017 SHALL latch in_size on the first beat of a row and ignore in_size on later beats of that row.
REQ-018 SHALL use states IDLE (empty), FILL (1..B-1 beats held), FULL (row presented).
REQ-019 SHALL transition IDLE->FULL on accepted beat when B==1, else IDLE->FILL; FILL->FULL on the B-th accepted beat; FULL->IDLE on output handshake without concurrent input beat.
REQ-020 SHALL drive in_ready=1 in IDLE and FILL; in FULL, in_ready SHALL equal out_ready (combinational pass-through).
REQ-021 SHALL, on simultaneous output handshake and input beat in FULL, retire the row and treat the beat as first beat of the next row: next state FULL if B==1, else FILL; all stale samples cleared to zero.
REQ-022 SHALL assert out_valid exactly in FULL; out_data, out_size, out_row, out_last SHALL be registered and stable while out_valid&!out_ready.
REQ-023 SHALL deliver a row one cycle after its final beat is accepted (out_valid rises the next cycle).
REQ-024 SHALL keep a row counter: incremented on each output handshake, wrapped to 0 after row N-1 where N=4/8/16/32 for size 0/1/2/3.
REQ-025 SHALL reset the row counter to 0 when the first beat of a row carries a size different from the previous row's size.
REQ-026 SHALL pass samples unmodified (no arithmetic, no saturation); width of each sample stays DATA_W.
REQ-027 SHALL ignore in_data and in_size whenever in_valid is low.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, beat count 0, row counter 0, out_data all zero, out_size 0, out_valid 0, out_last 0, out_row 0, out_bfly_en 0.
REQ-029 SHALL discard any partial or presented row when rst_n asserts mid-operation; first accepted beat after release starts a new row 0.
REQ-030 SHALL have in_ready=1 in the first cycle after reset release.

Verification
REQ-031 Size 32, four beats samples 0..31 = n+1, out_ready=1 -> one cycle after beat 4, out_valid=1, sample n=n+1, out_bfly_en=1, out_row=0.
REQ-032 Size 4, beat lanes = 5,6,7,8,9..12 -> samples 0..3 = 5,6,7,8, samples 4..31 = 0, out_bfly_en=0; four such rows -> out_last=1 on 4th, out_row wraps to 0 on 5th.
REQ-033 Size 16 row presented, out_ready held 0 three cycles -> in_ready=0, out_data unchanged; out_ready=1 with in_valid=1 size 8 beat -> same cycle both handshakes, next cycle new row FULL with samples 8..31 zero, out_row=0.
REQ-034 Size 32 after 2 of 4 beats, assert rst_n=0 one cycle -> out_valid=0, outputs zero; next 4 beats form a clean row 0 with no residue.
REQ-035 Size 32 beat with in_size changed to 0 on beats 2..4 -> out_size=3, all 32 samples assembled, row counter advances per size 32.
REQ-036 Back-to-back size 8 stream, in_valid and out_ready constantly 1 -> one row per cycle after first, out_row 0..7 repeating, out_last on row 7.
